// File: rtl/sprite_palette_anim.sv
// Multi-bank colour palette with a 2-stage lookup and frame-driven bank cycling.
// Define PALETTE_TRANSPARENT_EN to add a 'transparent' output that flags index 0.
module sprite_palette_anim #(
    parameter  int INDEX_W     = 4,
    parameter  int COLOR_W     = 4,
    parameter  int NUM_BANKS   = 2,
    parameter  int FRAME_TICKS = 4,
    localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int RGB_W       = 3 * COLOR_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               pix_valid,
    input  logic [INDEX_W-1:0] pix_index,
    input  logic               wr_en,
    input  logic [BANK_W-1:0]  wr_bank,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [RGB_W-1:0]   wr_rgb,
    input  logic               frame_tick,
    input  logic               anim_en,
    input  logic               bank_load,
    input  logic [BANK_W-1:0]  bank_sel,
    output logic               rgb_valid,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
`ifdef PALETTE_TRANSPARENT_EN
    output logic               transparent,
`endif
    output logic [BANK_W-1:0]  active_bank
);

    localparam int CNT_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int ADDR_W = BANK_W + INDEX_W;
    localparam int DEPTH  = 2 ** INDEX_W;
    localparam int SLOTS  = 2 ** ADDR_W;

    logic [RGB_W-1:0]  pal [SLOTS];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [RGB_W-1:0]  rd_data;

    logic [BANK_W-1:0] bank_q, bank_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              s1_valid_q;
    logic [RGB_W-1:0]  s1_rgb_q;
    logic              out_valid_q;
    logic [RGB_W-1:0]  out_rgb_q;

    assign wr_addr = {wr_bank, wr_index};
    assign rd_addr = {bank_q, pix_index};
    assign rd_data = pal[rd_addr];

    // Slots beyond NUM_BANKS have no storage, so writes to them vanish.
    for (genvar e = 0; e < SLOTS; e++) begin : g_ent
        if ((e / DEPTH) < NUM_BANKS) begin : g_real
            logic [RGB_W-1:0] ent_q;
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    ent_q <= '0;
                end else if (wr_en && (wr_addr == ADDR_W'(e))) begin
                    ent_q <= wr_rgb;
                end
            end
            assign pal[e] = ent_q;
        end else begin : g_none
            assign pal[e] = '0;
        end
    end

    always_comb begin
        bank_d = bank_q;
        cnt_d  = cnt_q;
        if (bank_load) begin
            cnt_d = '0;
            if (32'(bank_sel) < NUM_BANKS) begin
                bank_d = bank_sel;
            end
        end else if (anim_en && frame_tick) begin
            if (cnt_q == CNT_W'(FRAME_TICKS - 1)) begin
                cnt_d  = '0;
                bank_d = (bank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : bank_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bank_q <= '0;
            cnt_q  <= '0;
        end else begin
            bank_q <= bank_d;
            cnt_q  <= cnt_d;
        end
    end

    // Stage 1 reads the palette before any same-edge write lands.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid_q  <= 1'b0;
            s1_rgb_q    <= '0;
            out_valid_q <= 1'b0;
            out_rgb_q   <= '0;
        end else begin
            s1_valid_q  <= pix_valid;
            out_valid_q <= s1_valid_q;
            if (pix_valid) begin
                s1_rgb_q <= rd_data;
            end
            if (s1_valid_q) begin
                out_rgb_q <= s1_rgb_q;
            end
        end
    end

`ifdef PALETTE_TRANSPARENT_EN
    logic s1_transp_q;
    logic out_transp_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_transp_q  <= 1'b0;
            out_transp_q <= 1'b0;
        end else begin
            if (pix_valid) begin
                s1_transp_q <= (pix_index == '0);
            end
            if (s1_valid_q) begin
                out_transp_q <= s1_transp_q;
            end
        end
    end

    assign transparent = out_transp_q;
`endif

    assign rgb_valid   = out_valid_q;
    assign red         = out_rgb_q[RGB_W-1 -: COLOR_W];
    assign green       = out_rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue        = out_rgb_q[COLOR_W-1:0];
    assign active_bank = bank_q;

endmodule

// File: tb/tb_sprite_palette_anim.sv
// Directed bench for sprite_palette_anim: lookup latency, collisions,
// bank animation, load priority and async reset; second instance has 3 banks.
module tb_sprite_palette_anim;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        pix_valid;
    logic [3:0]  pix_index;
    logic        wr_en;
    logic [0:0]  wr_bank;
    logic [3:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        frame_tick;
    logic        anim_en;
    logic        bank_load;
    logic [0:0]  bank_sel;
    logic        rgb_valid;
    logic [3:0]  red, green, blue;
    logic [0:0]  active_bank;
    logic [11:0] rgb;

    logic        wr_en3;
    logic [1:0]  wr_bank3;
    logic        anim_en3;
    logic        bank_load3;
    logic [1:0]  bank_sel3;
    logic        rgb_valid3;
    logic [3:0]  red3, green3, blue3;
    logic [1:0]  active_bank3;
    logic [11:0] rgb3;

`ifdef PALETTE_TRANSPARENT_EN
    logic        transparent;
    logic        transparent3;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    assign rgb  = {red, green, blue};
    assign rgb3 = {red3, green3, blue3};

    always #5 Clk = ~Clk;

    sprite_palette_anim dut (
        .Clk(Clk), .Reset(Reset),
        .pix_valid(pix_valid), .pix_index(pix_index),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_rgb(wr_rgb),
        .frame_tick(frame_tick), .anim_en(anim_en),
        .bank_load(bank_load), .bank_sel(bank_sel),
        .rgb_valid(rgb_valid), .red(red), .green(green), .blue(blue),
`ifdef PALETTE_TRANSPARENT_EN
        .transparent(transparent),
`endif
        .active_bank(active_bank)
    );

    sprite_palette_anim #(.NUM_BANKS(3), .FRAME_TICKS(2)) dut3 (
        .Clk(Clk), .Reset(Reset),
        .pix_valid(pix_valid), .pix_index(pix_index),
        .wr_en(wr_en3), .wr_bank(wr_bank3), .wr_index(wr_index), .wr_rgb(wr_rgb),
        .frame_tick(frame_tick), .anim_en(anim_en3),
        .bank_load(bank_load3), .bank_sel(bank_sel3),
        .rgb_valid(rgb_valid3), .red(red3), .green(green3), .blue(blue3),
`ifdef PALETTE_TRANSPARENT_EN
        .transparent(transparent3),
`endif
        .active_bank(active_bank3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [0:0] b, input logic [3:0] idx,
                      input logic [11:0] val);
        wr_en = 1'b1; wr_bank = b; wr_index = idx; wr_rgb = val;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic look(input logic [3:0] idx);
        pix_valid = 1'b1; pix_index = idx;
        tick();
        pix_valid = 1'b0;
        tick();
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic load(input logic [0:0] sel);
        bank_load = 1'b1; bank_sel = sel;
        tick();
        bank_load = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; pix_valid = 0; pix_index = 0;
        wr_en = 0; wr_bank = 0; wr_index = 0; wr_rgb = 0;
        frame_tick = 0; anim_en = 0; bank_load = 0; bank_sel = 0;
        wr_en3 = 0; wr_bank3 = 0; anim_en3 = 0; bank_load3 = 0; bank_sel3 = 0;
        #1;
        check("rst_valid", rgb_valid, 0);
        check("rst_rgb", rgb, 12'h000);
        check("rst_bank", active_bank, 0);
`ifdef PALETTE_TRANSPARENT_EN
        check("rst_transp", transparent, 0);
`endif
        tick(); tick();
        Reset = 1'b0;

        look(4'd5);
        check("rst_look_valid", rgb_valid, 1);
        check("rst_look_rgb", rgb, 12'h000);

        wr(0, 4'd3, 12'h287);
        wr(0, 4'd7, 12'hABC);
        pix_valid = 1; pix_index = 4'd3;
        tick();
        pix_index = 4'd7;
        tick();
        check("stream0_valid", rgb_valid, 1);
        check("stream0_rgb", rgb, 12'h287);
        pix_index = 4'd3;
        tick();
        check("stream1_valid", rgb_valid, 1);
        check("stream1_rgb", rgb, 12'hABC);
        pix_valid = 0;
        tick();
        check("stream2_valid", rgb_valid, 1);
        check("stream2_rgb", rgb, 12'h287);
        tick();
        check("idle_valid", rgb_valid, 0);
        check("idle_hold_rgb", rgb, 12'h287);

        wr(0, 4'd1, 12'h1FE);
        wr_en = 1; wr_bank = 0; wr_index = 4'd1; wr_rgb = 12'h586;
        pix_valid = 1; pix_index = 4'd1;
        tick();
        wr_en = 0;
        tick();
        check("coll_old", rgb, 12'h1FE);
        pix_valid = 0;
        tick();
        check("coll_new", rgb, 12'h586);

        wr(1, 4'd3, 12'h9A5);
        bank_load = 1; bank_sel = 1;
        pix_valid = 1; pix_index = 4'd3;
        tick();
        bank_load = 0;
        tick();
        check("cap_bank0", rgb, 12'h287);
        pix_valid = 0;
        tick();
        check("cap_bank1", rgb, 12'h9A5);
        check("cap_active", active_bank, 1);

        load(0);
        anim_en = 1;
        for (int t = 1; t <= 8; t++) begin
            ftick();
            check($sformatf("anim_t%0d", t), active_bank,
                  (t >= 4 && t < 8) ? 1 : 0);
        end
        anim_en = 0;
        for (int t = 0; t < 5; t++) ftick();
        check("anim_off", active_bank, 0);

        anim_en = 1;
        for (int t = 0; t < 3; t++) ftick();
        bank_load = 1; bank_sel = 0; frame_tick = 1;
        tick();
        bank_load = 0; frame_tick = 0;
        check("prio_sel0", active_bank, 0);
        for (int t = 0; t < 3; t++) ftick();
        check("prio_cnt3", active_bank, 0);
        bank_load = 1; bank_sel = 1; frame_tick = 1;
        tick();
        bank_load = 0; frame_tick = 0;
        check("prio_sel1", active_bank, 1);
        for (int t = 0; t < 3; t++) ftick();
        check("prio_cnt_clr", active_bank, 1);
        ftick();
        check("prio_wrap", active_bank, 0);
        anim_en = 0;

        bank_load3 = 1; bank_sel3 = 2'd2;
        tick();
        check("b3_load2", active_bank3, 2);
        bank_sel3 = 2'd3;
        tick();
        bank_load3 = 0;
        check("b3_sel3_ign", active_bank3, 2);
        wr_en3 = 1; wr_bank3 = 2'd3; wr_index = 4'd0; wr_rgb = 12'hFFF;
        tick();
        wr_en3 = 0;
        look(4'd0);
        check("b3_wr3_ign", rgb3, 12'h000);
        wr_en3 = 1; wr_bank3 = 2'd2; wr_index = 4'd0; wr_rgb = 12'h123;
        tick();
        wr_en3 = 0;
        look(4'd0);
        check("b3_wr2", rgb3, 12'h123);
        anim_en3 = 1;
        ftick(); ftick();
        anim_en3 = 0;
        check("b3_wrap", active_bank3, 0);

        load(1);
        pix_valid = 1; pix_index = 4'd3;
        tick(); tick();
        check("pre_rst_rgb", rgb, 12'h9A5);
        #3 Reset = 1'b1;
        #1;
        check("arst_valid", rgb_valid, 0);
        check("arst_rgb", rgb, 12'h000);
        check("arst_bank", active_bank, 0);
        pix_valid = 0;
        @(negedge Clk);
        Reset = 1'b0;
        tick(); tick();
        check("post_rst_valid", rgb_valid, 0);
        look(4'd3);
        check("post_rst_look_v", rgb_valid, 1);
        check("post_rst_look", rgb, 12'h000);

`ifdef PALETTE_TRANSPARENT_EN
        wr(0, 4'd0, 12'h4C2);
        look(4'd0);
        check("transp_idx0", transparent, 1);
        check("transp_idx0_rgb", rgb, 12'h4C2);
        look(4'd1);
        check("transp_idx1", transparent, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
